// File: rtl/mod_n_updown_counter.sv
// Programmable modulo-N up/down counter with synchronous load, range-checked
// load flag, registered wrap pulse and combinational terminal count for cascading.
module mod_n_updown_counter #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             load_err
);

  if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_param_chk
    $error("mod_n_updown_counter: MODULUS %0d outside 2..2**WIDTH", MODULUS);
  end

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
  // One extra bit so MODULUS == 2**WIDTH is representable for the range check.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_load_err;

  logic [WIDTH-1:0] w_count_nxt;
  logic             w_wrap_nxt;
  logic             w_err_nxt;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_in_range;

  assign w_at_max   = (r_count == MAX_CNT);
  assign w_at_zero  = (r_count == '0);
  assign w_in_range = ({1'b0, load_val} < MOD_EXT);

  always_comb begin
    w_count_nxt = r_count;
    w_wrap_nxt  = 1'b0;
    w_err_nxt   = r_load_err;
    if (load) begin
      if (w_in_range) begin
        w_count_nxt = load_val;
        w_err_nxt   = 1'b0;
      end else begin
        w_count_nxt = MAX_CNT;
        w_err_nxt   = 1'b1;
      end
    end else if (en) begin
      if (up_dn) begin
        if (w_at_max) begin
          w_count_nxt = '0;
          w_wrap_nxt  = 1'b1;
        end else begin
          w_count_nxt = r_count + WIDTH'(1);
        end
      end else begin
        if (w_at_zero) begin
          w_count_nxt = MAX_CNT;
          w_wrap_nxt  = 1'b1;
        end else begin
          w_count_nxt = r_count - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_wrap     <= w_wrap_nxt;
      r_load_err <= w_err_nxt;
    end
  end

  // Combinational so a downstream stage can use it as enable on the same edge.
  assign tc       = en & ~load & ((up_dn & w_at_max) | (~up_dn & w_at_zero));
  assign count    = r_count;
  assign wrap     = r_wrap;
  assign load_err = r_load_err;

endmodule
